// File: rtl/inert_yaw_intf.sv
// ============================================================================
// Module   : inert_yaw_intf
// Brief    : SPI master + sequencer that configures an iNEMO gyro and reads
//            its 16-bit yaw rate on every data-ready interrupt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inert_yaw_intf #(
    parameter int POR_BITS  = 16,
    parameter int SCLK_BITS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    input  logic        INT,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        init_done
);

    localparam logic [SCLK_BITS-1:0] c_DIV_LOAD = {{(SCLK_BITS-3){1'b1}}, 3'b000};
    localparam logic [SCLK_BITS-1:0] c_DIV_RISE = {1'b0, {(SCLK_BITS-1){1'b1}}};
    localparam logic [SCLK_BITS-1:0] c_DIV_FALL = '1;
    localparam logic [POR_BITS-1:0]  c_POR_MAX  = '1;

    localparam logic [2:0] c_ST_POR   = 3'd0;
    localparam logic [2:0] c_ST_CFG1  = 3'd1;
    localparam logic [2:0] c_ST_CFG2  = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_RDL   = 3'd4;
    localparam logic [2:0] c_ST_RDH   = 3'd5;

    // SPI master state
    logic                 ss_n_q;
    logic [SCLK_BITS-1:0] div_q;
    logic [15:0]          shft_q;
    logic                 smpl_q;
    logic [3:0]           bitcnt_q;
    logic                 first_q;
    logic                 porch_q;
    logic                 done_q;

    // Sequencer state
    logic [2:0]           state_q, state_d;
    logic [POR_BITS-1:0]  por_q;
    logic                 int_s1_q, int_s2_q;
    logic                 wrt_q, wrt_d;
    logic [15:0]          cmd_q, cmd_d;
    logic [7:0]           low_q;
    logic [15:0]          yaw_q;
    logic                 vld_q;
    logic                 init_q;
    logic                 set_init_d, latch_low_d, upd_yaw_d;

    logic                 w_smpl;
    logic                 w_fall;

    assign w_smpl = (div_q == c_DIV_RISE) && !porch_q;
    assign w_fall = (div_q == c_DIV_FALL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_n_q   <= 1'b1;
            div_q    <= '0;
            shft_q   <= '0;
            smpl_q   <= 1'b0;
            bitcnt_q <= '0;
            first_q  <= 1'b0;
            porch_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ss_n_q) begin
                if (wrt_q) begin
                    ss_n_q   <= 1'b0;
                    div_q    <= c_DIV_LOAD;
                    shft_q   <= cmd_q;
                    first_q  <= 1'b1;
                    porch_q  <= 1'b0;
                    bitcnt_q <= '0;
                end
            end else begin
                div_q <= div_q + 1'b1;
                if (w_smpl) begin
                    smpl_q   <= MISO;
                    bitcnt_q <= bitcnt_q + 1'b1;
                    if (bitcnt_q == 4'd15)
                        porch_q <= 1'b1;
                end
                // The back-porch fall slot also shifts, pulling in the 16th sample.
                if (w_fall) begin
                    first_q <= 1'b0;
                    if (!first_q)
                        shft_q <= {shft_q[14:0], smpl_q};
                    if (porch_q) begin
                        ss_n_q <= 1'b1;
                        done_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign SS_n = ss_n_q;
    assign SCLK = ss_n_q | porch_q | div_q[SCLK_BITS-1];
    assign MOSI = shft_q[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= c_ST_POR;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_POR:  if (por_q == c_POR_MAX) state_d = c_ST_CFG1;
            c_ST_CFG1: if (done_q)             state_d = c_ST_CFG2;
            c_ST_CFG2: if (done_q)             state_d = c_ST_WAIT;
            c_ST_WAIT: if (int_s2_q)           state_d = c_ST_RDL;
            c_ST_RDL:  if (done_q)             state_d = c_ST_RDH;
            c_ST_RDH:  if (done_q)             state_d = c_ST_WAIT;
            default:                           state_d = c_ST_POR;
        endcase
    end

    always_comb begin
        wrt_d       = 1'b0;
        cmd_d       = cmd_q;
        set_init_d  = 1'b0;
        latch_low_d = 1'b0;
        upd_yaw_d   = 1'b0;
        case (state_q)
            c_ST_POR:  if (por_q == c_POR_MAX) begin wrt_d = 1'b1; cmd_d = 16'h0D02; end
            c_ST_CFG1: if (done_q) begin wrt_d = 1'b1; cmd_d = 16'h1160; end
            c_ST_CFG2: if (done_q) set_init_d = 1'b1;
            c_ST_WAIT: if (int_s2_q) begin wrt_d = 1'b1; cmd_d = 16'hA600; end
            c_ST_RDL:  if (done_q) begin wrt_d = 1'b1; cmd_d = 16'hA700; latch_low_d = 1'b1; end
            c_ST_RDH:  if (done_q) upd_yaw_d = 1'b1;
            default:   ;
        endcase
    end

    // Registering the start request guarantees two idle SS_n cycles between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            por_q    <= '0;
            int_s1_q <= 1'b0;
            int_s2_q <= 1'b0;
            wrt_q    <= 1'b0;
            cmd_q    <= '0;
            low_q    <= '0;
            yaw_q    <= '0;
            vld_q    <= 1'b0;
            init_q   <= 1'b0;
        end else begin
            int_s1_q <= INT;
            int_s2_q <= int_s1_q;
            if ((state_q == c_ST_POR) && (por_q != c_POR_MAX))
                por_q <= por_q + 1'b1;
            wrt_q <= wrt_d;
            cmd_q <= cmd_d;
            vld_q <= upd_yaw_d;
            if (set_init_d)
                init_q <= 1'b1;
            if (latch_low_d)
                low_q <= shft_q[7:0];
            if (upd_yaw_d)
                yaw_q <= {shft_q[7:0], low_q};
        end
    end

    assign yaw_rt    = yaw_q;
    assign vld       = vld_q;
    assign init_done = init_q;

endmodule

`default_nettype wire

// File: tb/tb_inert_yaw_intf.sv
// ============================================================================
// Module   : tb_inert_yaw_intf
// Brief    : Directed bench for inert_yaw_intf with a behavioural iNEMO slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inert_yaw_intf;

    localparam int POR_BITS  = 10;
    localparam int SCLK_BITS = 5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        MISO  = 1'b0;
    logic        INT   = 1'b0;
    logic        SS_n, SCLK, MOSI, vld, init_done;
    logic [15:0] yaw_rt;

    inert_yaw_intf #(.POR_BITS(POR_BITS), .SCLK_BITS(SCLK_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .INT(INT), .yaw_rt(yaw_rt), .vld(vld), .init_done(init_done)
    );

    initial forever #5 clk = ~clk;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tx_start_n = 0;
    int          rd26_n = 0;
    int          vld_n = 0;
    logic [15:0] yaw_model = 16'h0000;
    logic [15:0] words[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Bus monitor and iNEMO slave model, both sampled on the falling clk edge.
    initial begin : mon
        logic        p_ss, p_sclk, in_tx, per_bad;
        int          falls, rises, t0, t_first, t_lf, t_lr, t_ssr;
        logic [15:0] word;
        logic [7:0]  dbyte;
        p_ss = 1'b1; p_sclk = 1'b1; in_tx = 1'b0; per_bad = 1'b0;
        falls = 0; rises = 0; t0 = 0; t_first = 0; t_lf = 0; t_lr = 0; t_ssr = -100;
        word = '0; dbyte = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_tx = 1'b0; p_ss = 1'b1; p_sclk = 1'b1; MISO = 1'b0;
            end else begin
                if (vld) vld_n++;
                if (p_ss && !SS_n) begin
                    in_tx = 1'b1; t0 = cyc; falls = 0; rises = 0; word = '0;
                    per_bad = 1'b0; dbyte = '0; MISO = 1'b0;
                    tx_start_n++;
                    chki("ss_high_gap_ge2", (cyc - t_ssr >= 2) ? 1 : 0, 1);
                end
                if (in_tx && !SS_n && p_sclk && !SCLK) begin
                    falls++;
                    if (falls == 1) t_first = cyc;
                    else if (cyc - t_lf != 32) per_bad = 1'b1;
                    t_lf = cyc;
                    MISO = (rises >= 8 && rises < 16) ? dbyte[15 - rises] : 1'b0;
                end
                if (in_tx && !SS_n && !p_sclk && SCLK) begin
                    rises++;
                    word = {word[14:0], MOSI};
                    t_lr = cyc;
                    if (rises == 8)
                        dbyte = (word[7:0] == 8'hA6) ? yaw_model[7:0] :
                                (word[7:0] == 8'hA7) ? yaw_model[15:8] : 8'h00;
                end
                if (in_tx && !p_ss && SS_n) begin
                    in_tx = 1'b0;
                    chki("sclk_falls", falls, 16);
                    chki("first_fall_delay", t_first - t0, 8);
                    chki("sclk_period_32", per_bad ? 0 : 1, 1);
                    chki("last_rise_to_ss_rise", cyc - t_lr, 16);
                    words.push_back(word);
                    if (word[15:8] == 8'hA6) rd26_n++;
                    t_ssr = cyc;
                    MISO = 1'b0;
                end
                p_ss = SS_n;
                p_sclk = SCLK;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic por_and_cfg(input int base, input logic chk_rd);
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (SS_n && n < 4000);
        chki("por_wait_cycles_ok", (n >= (1 << POR_BITS) && n <= (1 << POR_BITS) + 2) ? 1 : 0, 1);
        n = 0;
        while (!init_done && n < 3000) begin @(posedge clk); #1; n++; end
        chki("init_done_rise", init_done ? 1 : 0, 1);
        chki("cfg_words_before_init", words.size() - base, 2);
        if (words.size() >= base + 2) begin
            chk16("mosi_cfg1", words[base], 16'h0D02);
            chk16("mosi_cfg2", words[base+1], 16'h1160);
        end
        if (chk_rd) begin
            n = 0;
            while (SS_n && n < 10) begin @(posedge clk); #1; n++; end
            chki("read_within_3clk", (n <= 3 && !SS_n) ? 1 : 0, 1);
        end
    endtask

    task automatic wait_rd26(input int target);
        int n;
        n = 0;
        while (rd26_n < target && n < 3000) begin @(posedge clk); #1; n++; end
        chki("rd26_done", (rd26_n >= target) ? 1 : 0, 1);
    endtask

    task automatic wait_vld(input logic [15:0] prev);
        int   n;
        logic held_ok;
        n = 0; held_ok = 1'b1;
        while (!vld && n < 3000) begin
            @(posedge clk); #1; n++;
            if (!vld && yaw_rt !== prev) held_ok = 1'b0;
        end
        chki("vld_seen", vld ? 1 : 0, 1);
        chki("yaw_held_until_vld", held_ok ? 1 : 0, 1);
    endtask

    typedef struct {
        logic [15:0] yaw_in;
        logic [15:0] exp_yaw;
    } vec_t;

    initial begin : main
        vec_t        vecs[5];
        int          b, vb, r, n, wb;
        logic [15:0] prev;
        vecs[0] = '{16'h1234, 16'h1234};
        vecs[1] = '{16'hFF80, 16'hFF80};
        vecs[2] = '{16'h0000, 16'h0000};
        vecs[3] = '{16'h8001, 16'h8001};
        vecs[4] = '{16'h7FFF, 16'h7FFF};

        repeat (3) @(posedge clk);
        #1;
        chk16("rst_ss_n", {15'd0, SS_n}, 16'd1);
        chk16("rst_sclk", {15'd0, SCLK}, 16'd1);
        chk16("rst_mosi", {15'd0, MOSI}, 16'd0);
        chk16("rst_yaw", yaw_rt, 16'h0000);
        chk16("rst_vld", {15'd0, vld}, 16'd0);
        chk16("rst_init", {15'd0, init_done}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        por_and_cfg(0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            yaw_model = vecs[i].yaw_in;
            b = words.size(); vb = vld_n; prev = yaw_rt; r = rd26_n;
            @(negedge clk);
            INT = 1'b1;
            wait_rd26(r + 1);
            INT = 1'b0;
            wait_vld(prev);
            chk16("yaw_rt", yaw_rt, vecs[i].exp_yaw);
            repeat (80) @(posedge clk);
            #1;
            chki("vld_pulses", vld_n - vb, 1);
            chki("read_words", words.size() - b, 2);
            if (words.size() >= b + 2) begin
                chk16("mosi_rd_l", words[b], 16'hA600);
                chk16("mosi_rd_h", words[b+1], 16'hA700);
            end
            chk16("yaw_rt_hold", yaw_rt, vecs[i].exp_yaw);
        end

        // INT held across a full read pair: a second read follows immediately.
        yaw_model = 16'h5A5A;
        b = words.size(); vb = vld_n; r = rd26_n;
        @(negedge clk);
        INT = 1'b1;
        wait_rd26(r + 2);
        INT = 1'b0;
        n = 0;
        while (vld_n < vb + 2 && n < 3000) begin @(posedge clk); #1; n++; end
        repeat (80) @(posedge clk);
        #1;
        chki("b2b_vld_pulses", vld_n - vb, 2);
        chki("b2b_words", words.size() - b, 4);
        if (words.size() >= b + 4) begin
            chk16("b2b_rd_l2", words[b+2], 16'hA600);
            chk16("b2b_rd_h2", words[b+3], 16'hA700);
        end
        chk16("b2b_yaw", yaw_rt, 16'h5A5A);

        // Reset in the middle of the high-byte read, with INT held high throughout.
        yaw_model = 16'h4321;
        b = tx_start_n;
        @(negedge clk);
        INT = 1'b1;
        n = 0;
        while (tx_start_n < b + 2 && n < 3000) begin @(posedge clk); #1; n++; end
        chki("rdh_started", (tx_start_n >= b + 2) ? 1 : 0, 1);
        repeat (100) @(posedge clk);
        wb = words.size();
        #3;
        rst_n = 1'b0;
        #1;
        chk16("midrst_ss_n", {15'd0, SS_n}, 16'd1);
        chk16("midrst_sclk", {15'd0, SCLK}, 16'd1);
        chk16("midrst_vld", {15'd0, vld}, 16'd0);
        chk16("midrst_yaw", yaw_rt, 16'h0000);
        chk16("midrst_init", {15'd0, init_done}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        por_and_cfg(wb, 1'b1);
        r = rd26_n;
        prev = yaw_rt;
        wait_rd26(r + 1);
        INT = 1'b0;
        wait_vld(prev);
        chk16("post_rst_yaw", yaw_rt, 16'h4321);
        if (words.size() >= wb + 4) begin
            chk16("post_rst_rd_l", words[wb+2], 16'hA600);
            chk16("post_rst_rd_h", words[wb+3], 16'hA700);
        end else begin
            chki("post_rst_words", words.size() - wb, 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inert_yaw_intf.md
INERT_YAW_INTF -- requirements
Module: inert_yaw_intf

Interface
REQ-001 Parameter POR_BITS, default 16: width of the power-on wait timer; the wait is 2^POR_BITS clk cycles.
REQ-002 Parameter SCLK_BITS, default 5: width of the SCLK divider; SCLK period is 2^SCLK_BITS clk cycles.
REQ-003 clk  input  1  system clock; the only clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 SS_n  output  1  SPI slave select to the iNEMO, active low.
REQ-006 SCLK  output  1  SPI serial clock; idles high.
REQ-007 MOSI  output  1  SPI serial data to the iNEMO, MSB first.
REQ-008 MISO  input  1  SPI serial data from the iNEMO.
REQ-009 INT  input  1  iNEMO data-ready interrupt; asynchronous to clk.
REQ-010 yaw_rt  output  16  most recent signed yaw rate, {reg 0x27, reg 0x26}.
REQ-011 vld  output  1  one-clk pulse when yaw_rt has been updated.
REQ-012 init_done  output  1  high once both configuration writes have completed; stays high until reset.

Function -- SPI master
REQ-013 Every transaction SHALL be exactly 16 bits, full duplex; byte 1 = {R/Wn, addr[6:0]} with R/Wn=1 for read, byte 2 = write data or 0x00 for reads.
REQ-014 On transaction start SS_n SHALL fall in the same cycle and the divider SHALL load 2^SCLK_BITS-8 (0x18 at default), giving a front porch before the first SCLK fall.
REQ-015 SCLK SHALL equal divider MSB while SS_n is low, and 1 while SS_n is high.
REQ-016 MISO SHALL be sampled into the shift register's LSB on the clk in which the divider equals 0x0F (SCLK about to rise); the shift register SHALL shift left when the divider equals 0x1F (SCLK falls), except on the first fall after SS_n low.
REQ-017 MOSI SHALL be shift_reg[15] at all times.
REQ-018 After the 16th sample the master SHALL hold SCLK high, wait through the back porch until the divider reaches 0x1F, then raise SS_n; the transaction is done that same cycle, and the shift register holds the 16 received bits.
REQ-019 Back-to-back transactions SHALL keep SS_n high for at least 2 clk cycles.

Function -- sequencer
REQ-020 INT SHALL pass through a 2-flop synchronizer; only the synchronized value is used.
REQ-021 The sequencer SHALL be a state machine with these states and transitions:
- POR_WAIT: the timer counts up; when it saturates, go to CFG1.
- CFG1: send 0x0D02 (INT1 on data-ready); when done, go to CFG2.
- CFG2: send 0x1160 (gyro ODR); when done, set init_done and go to WAIT_INT.
- WAIT_INT: when synchronized INT=1, go to RD_L.
- RD_L: send 0xA600; when done, latch rx[7:0] into a low holding register and go to RD_H.
- RD_H: send 0xA700; when done, set yaw_rt = {rx[7:0], low}, pulse vld for 1 clk, and go to WAIT_INT.
REQ-022 yaw_rt SHALL change only in the cycle vld pulses; the upper and lower bytes of any presented yaw_rt SHALL come from the same INT event.
REQ-023 INT still high when returning to WAIT_INT SHALL start a new read immediately; INT edges during a read SHALL NOT abort or restart it.
REQ-024 While init_done=0, INT SHALL be ignored.

Reset
REQ-025 On rst_n low, all state SHALL clear asynchronously: SS_n=1, SCLK=1, MOSI=0, yaw_rt=0, vld=0, init_done=0, state=POR_WAIT, POR timer=0.
REQ-026 Reset mid-transaction SHALL abandon the transaction immediately (SS_n high the same instant); after release, the full POR_WAIT and configuration sequence SHALL repeat.

Verification
REQ-027 Reset release, MISO tied 0 -> SS_n stays high for 2^16 clk; then two transactions whose MOSI bits are 0x0D02 and 0x1160; init_done rises after the second SS_n rise.
REQ-028 Per-transaction timing check -> exactly 16 SCLK falls while SS_n low, SCLK period 32 clk, first fall 8 clk after SS_n falls, SS_n rises 16 clk after the last SCLK rise.
REQ-029 With the iNEMO slave model and YAW=0x1234, after setup the model asserts INT -> MOSI shows 0xA600 then 0xA700; vld pulses once; yaw_rt=0x1234; INT clears after the 0x26 read.
REQ-030 YAW changed 0x1234 -> 0xFF80 between INT events -> the next vld gives yaw_rt=0xFF80; yaw_rt holds 0x1234 until that pulse.
REQ-031 INT held high before init_done -> no read issued; first read starts within 3 clk after init_done.
REQ-032 rst_n pulsed low during the RD_H transaction -> SS_n=1 and vld=0 immediately; yaw_rt=0; POR wait and both configuration writes repeat before any further read.
